// File: rtl/l2_cache_pkg.sv
// Shared types and codes for the L2 cache tag/state model.
package l2_cache_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [2:0] {
        BUS_NONE       = 3'd0,
        BUS_READ       = 3'd1,
        BUS_WRITE      = 3'd2,
        BUS_INVALIDATE = 3'd3,
        BUS_RWIM       = 3'd4
    } bus_op_t;

    typedef enum logic [1:0] {
        SNOOP_NOHIT = 2'd0,
        SNOOP_HIT   = 2'd1,
        SNOOP_HITM  = 2'd2
    } snoop_t;

    localparam logic [7:0] CMD_READ      = 8'd0;
    localparam logic [7:0] CMD_WRITE     = 8'd1;
    localparam logic [7:0] CMD_IFETCH    = 8'd2;
    localparam logic [7:0] CMD_SNP_INV   = 8'd3;
    localparam logic [7:0] CMD_SNP_READ  = 8'd4;
    localparam logic [7:0] CMD_SNP_WRITE = 8'd5;
    localparam logic [7:0] CMD_SNP_RWIM  = 8'd6;
    localparam logic [7:0] CMD_CLEAR     = 8'd8;
    localparam logic [7:0] CMD_PRINT     = 8'd9;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_BUS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/l2_plru8.sv
// 8-way tree pseudo-LRU: victim selection and post-access tree update.
// Tree bit = 1 steers the victim toward the upper half of that node.
// Node 0 is the root, nodes 1/2 cover ways 0-3/4-7, nodes 3..6 cover way pairs.
module l2_plru8 (
    input  logic [6:0] tree,
    input  logic [2:0] access_way,
    output logic [2:0] victim,
    output logic [6:0] tree_next
);

    // Walk the tree from the root following the stored direction bits.
    always_comb begin
        victim    = '0;
        victim[2] = tree[0];
        victim[1] = tree[0] ? tree[2] : tree[1];
        case (victim[2:1])
            2'b00:   victim[0] = tree[3];
            2'b01:   victim[0] = tree[4];
            2'b10:   victim[0] = tree[5];
            default: victim[0] = tree[6];
        endcase
    end

    // Point every node on the accessed way's path away from that way.
    always_comb begin
        tree_next    = tree;
        tree_next[0] = ~access_way[2];
        if (!access_way[2]) begin
            tree_next[1] = ~access_way[1];
            if (!access_way[1]) tree_next[3] = ~access_way[0];
            else                tree_next[4] = ~access_way[0];
        end else begin
            tree_next[2] = ~access_way[1];
            if (!access_way[1]) tree_next[5] = ~access_way[0];
            else                tree_next[6] = ~access_way[0];
        end
    end

endmodule

// File: rtl/l2_cache.sv
// L2 cache tag/MESI/PLRU model: one trace command at a time, issues bus ops
// and reports hit/miss and its own snoop result.
module l2_cache
    import l2_cache_pkg::*;
#(
    parameter int ways            = 8,
    parameter int indexBits       = 14,
    parameter int lineSize        = 512,
    parameter int tagBits         = 10,
    parameter int commandSize     = 8,
    parameter int instructionSize = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    input  logic [commandSize-1:0]     command,
    input  logic [instructionSize-1:0] address,
    output logic                       ready,
    output logic                       resp_valid,
    output logic                       hit,
    output logic                       miss,
    output logic                       busValid,
    output logic [2:0]                 busOp,
    output logic [instructionSize-1:0] busAddr,
    input  logic [1:0]                 sharedBus,
    output logic [1:0]                 snoopBus
);

    localparam int offsetBits = $clog2(lineSize / 8);
    localparam int sets       = 1 << indexBits;
    localparam int wayBits    = $clog2(ways);
    localparam int lineBits   = instructionSize - offsetBits;
    localparam int padBits    = lineBits - indexBits - tagBits;

    logic [tagBits-1:0]   tag_arr  [sets][ways];
    mesi_t                mesi_arr [sets][ways];
    logic [ways-2:0]      plru_arr [sets];

    state_t               state, state_next;
    logic [indexBits-1:0] clear_idx;
    logic [commandSize-1:0] cmd_r;
    logic [lineBits-1:0]  line_r;

    logic                 hit_r, miss_r, bus_r, fill_r;
    bus_op_t              op_r;
    snoop_t               snoop_r;
    logic [wayBits-1:0]   way_r;
    logic [instructionSize-1:0] wb_addr_r;

    logic [indexBits-1:0] idx;
    logic [tagBits-1:0]   tg;
    logic                 hit_any, inv_any;
    logic [wayBits-1:0]   hit_way, inv_way, plru_victim, victim, acc_way;
    mesi_t                hstate, vstate;
    logic [ways-2:0]      plru_cur, plru_next;
    logic [instructionSize-1:0] line_addr, victim_addr;

    logic                 d_hit, d_miss, d_wb, d_bus, d_fill, d_set, d_plru;
    bus_op_t              d_op;
    snoop_t               d_snoop;
    mesi_t                d_state;
    logic [instructionSize-1:0] d_wb_addr;

    logic                 unused_offset;
    assign unused_offset = ^address[offsetBits-1:0];

    assign idx         = line_r[indexBits-1:0];
    assign tg          = line_r[indexBits +: tagBits];
    assign plru_cur    = plru_arr[idx];
    assign line_addr   = {line_r, {offsetBits{1'b0}}};
    assign victim_addr = {{padBits{1'b0}}, tag_arr[idx][victim], idx, {offsetBits{1'b0}}};
    assign hstate      = mesi_arr[idx][hit_way];
    assign vstate      = mesi_arr[idx][victim];
    assign victim      = inv_any ? inv_way : plru_victim;
    assign acc_way     = hit_any ? hit_way : victim;

    l2_plru8 u_plru (
        .tree       (plru_cur),
        .access_way (acc_way),
        .victim     (plru_victim),
        .tree_next  (plru_next)
    );

    // Tag compare across all ways and lowest-numbered invalid way search.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int unsigned w = 0; w < ways; w++) begin
            if (!hit_any && mesi_arr[idx][wayBits'(w)] != MESI_I &&
                tag_arr[idx][wayBits'(w)] == tg) begin
                hit_any = 1'b1;
                hit_way = wayBits'(w);
            end
            if (!inv_any && mesi_arr[idx][wayBits'(w)] == MESI_I) begin
                inv_any = 1'b1;
                inv_way = wayBits'(w);
            end
        end
    end

    // Per-command decision taken in LOOKUP: state change, bus work, responses.
    always_comb begin
        d_hit     = hit_any;
        d_miss    = 1'b0;
        d_wb      = 1'b0;
        d_bus     = 1'b0;
        d_fill    = 1'b0;
        d_set     = 1'b0;
        d_plru    = 1'b0;
        d_op      = BUS_NONE;
        d_snoop   = SNOOP_NOHIT;
        d_state   = MESI_I;
        d_wb_addr = victim_addr;
        case (cmd_r)
            CMD_READ, CMD_IFETCH: begin
                d_plru = 1'b1;
                if (!hit_any) begin
                    d_miss = 1'b1;
                    d_wb   = (vstate == MESI_M);
                    d_bus  = 1'b1;
                    d_op   = BUS_READ;
                    d_fill = 1'b1;
                end
            end
            CMD_WRITE: begin
                d_plru = 1'b1;
                if (hit_any) begin
                    d_set   = 1'b1;
                    d_state = MESI_M;
                    if (hstate == MESI_S) begin
                        d_bus = 1'b1;
                        d_op  = BUS_INVALIDATE;
                    end
                end else begin
                    d_miss = 1'b1;
                    d_wb   = (vstate == MESI_M);
                    d_bus  = 1'b1;
                    d_op   = BUS_RWIM;
                    d_fill = 1'b1;
                end
            end
            CMD_SNP_INV: begin
                if (hit_any) begin
                    d_snoop = SNOOP_HIT;
                    if (hstate == MESI_S) d_set = 1'b1;
                end
            end
            CMD_SNP_READ, CMD_SNP_RWIM: begin
                if (hit_any) begin
                    d_set   = 1'b1;
                    d_state = (cmd_r == CMD_SNP_READ) ? MESI_S : MESI_I;
                    d_snoop = SNOOP_HIT;
                    if (hstate == MESI_M) begin
                        d_wb      = 1'b1;
                        d_wb_addr = line_addr;
                        d_snoop   = SNOOP_HITM;
                    end
                end
            end
            CMD_SNP_WRITE: d_snoop = SNOOP_NOHIT;
            CMD_PRINT:     d_hit   = 1'b0;
            default:       d_hit   = 1'b0;
        endcase
    end

    // FSM next state and Moore outputs.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        resp_valid = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        busValid   = 1'b0;
        busOp      = BUS_NONE;
        busAddr    = '0;
        snoopBus   = SNOOP_NOHIT;
        case (state)
            ST_CLEAR:  if (clear_idx == '1) state_next = ST_IDLE;
            ST_IDLE: begin
                ready = 1'b1;
                if (cmd_valid) state_next = (command == CMD_CLEAR) ? ST_CLEAR : ST_LOOKUP;
            end
            ST_LOOKUP: state_next = d_wb ? ST_WB : (d_bus ? ST_BUS : ST_RESP);
            ST_WB: begin
                busValid   = 1'b1;
                busOp      = BUS_WRITE;
                busAddr    = wb_addr_r;
                state_next = bus_r ? ST_BUS : ST_RESP;
            end
            ST_BUS: begin
                busValid   = 1'b1;
                busOp      = op_r;
                busAddr    = line_addr;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                hit        = hit_r;
                miss       = miss_r;
                snoopBus   = snoop_r;
                state_next = ST_IDLE;
            end
            default:   state_next = ST_CLEAR;
        endcase
    end

    // Control state: FSM register, sweep counter, latched command and lookup result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
            cmd_r     <= '0;
            line_r    <= '0;
            hit_r     <= 1'b0;
            miss_r    <= 1'b0;
            bus_r     <= 1'b0;
            fill_r    <= 1'b0;
            op_r      <= BUS_NONE;
            snoop_r   <= SNOOP_NOHIT;
            way_r     <= '0;
            wb_addr_r <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) clear_idx <= clear_idx + 1'b1;
            if (state == ST_IDLE && cmd_valid) begin
                cmd_r     <= command;
                line_r    <= address[instructionSize-1:offsetBits];
                clear_idx <= '0;
            end
            if (state == ST_LOOKUP) begin
                hit_r     <= d_hit;
                miss_r    <= d_miss;
                bus_r     <= d_bus;
                fill_r    <= d_fill;
                op_r      <= d_op;
                snoop_r   <= d_snoop;
                way_r     <= victim;
                wb_addr_r <= d_wb_addr;
            end
        end
    end

    // Tag/MESI/PLRU storage; only the CLEAR sweep brings it to a known state.
    always_ff @(posedge clk) begin
        case (state)
            ST_CLEAR: begin
                for (int unsigned w = 0; w < ways; w++) mesi_arr[clear_idx][wayBits'(w)] <= MESI_I;
                plru_arr[clear_idx] <= '0;
            end
            ST_LOOKUP: begin
                if (d_plru) plru_arr[idx] <= plru_next;
                if (d_set)  mesi_arr[idx][hit_way] <= d_state;
            end
            ST_BUS: begin
                // Fill waits for the bus cycle so sharedBus can pick E or S.
                if (fill_r) begin
                    tag_arr[idx][way_r] <= tg;
                    if (op_r == BUS_RWIM)              mesi_arr[idx][way_r] <= MESI_M;
                    else if (sharedBus == SNOOP_NOHIT) mesi_arr[idx][way_r] <= MESI_E;
                    else                               mesi_arr[idx][way_r] <= MESI_S;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_cache.sv
// Directed self-checking bench for l2_cache.
module tb_l2_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [7:0]  command;
    logic [31:0] address;
    logic        ready, resp_valid, hit, miss, busValid;
    logic [2:0]  busOp;
    logic [31:0] busAddr;
    logic [1:0]  sharedBus;
    logic [1:0]  snoopBus;

    int          n_cmp = 0;
    int          n_err = 0;

    int          r_lat, r_nops, r_done;
    logic [2:0]  r_op0, r_op1;
    logic [31:0] r_addr0, r_addr1;
    logic        r_hit, r_miss;
    logic [1:0]  r_snoop;
    int          low_cnt;

    always #5 clk = ~clk;

    l2_cache #(
        .ways            (8),
        .indexBits       (14),
        .lineSize        (512),
        .tagBits         (10),
        .commandSize     (8),
        .instructionSize (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .command    (command),
        .address    (address),
        .ready      (ready),
        .resp_valid (resp_valid),
        .hit        (hit),
        .miss       (miss),
        .busValid   (busValid),
        .busOp      (busOp),
        .busAddr    (busAddr),
        .sharedBus  (sharedBus),
        .snoopBus   (snoopBus)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Issue one command and record bus ops and the response.
    task automatic run_cmd(input logic [7:0] c, input logic [31:0] a, input logic [1:0] s);
        int got;
        got = 0;
        r_lat = 0; r_nops = 0; r_done = 0;
        r_op0 = '0; r_op1 = '0; r_addr0 = '0; r_addr1 = '0;
        r_hit = 1'b0; r_miss = 1'b0; r_snoop = '0;
        @(negedge clk);
        cmd_valid = 1'b1; command = c; address = a; sharedBus = s;
        for (int i = 0; i < 40 && got == 0; i++) begin
            if (ready) got = 1;
            else @(negedge clk);
        end
        if (got == 0) begin
            cmd_valid = 1'b0;
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            for (int cyc = 1; cyc <= 30 && r_done == 0; cyc++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                if (busValid) begin
                    if (r_nops == 0) begin r_op0 = busOp; r_addr0 = busAddr; end
                    else if (r_nops == 1) begin r_op1 = busOp; r_addr1 = busAddr; end
                    r_nops++;
                end
                if (resp_valid) begin
                    r_done = 1; r_lat = cyc;
                    r_hit = hit; r_miss = miss; r_snoop = snoopBus;
                end
            end
            check("resp_timeout", r_done, 32'd1);
        end
    endtask

    // Issue cmd 8 and count cycles with ready low after acceptance.
    task automatic do_clear(output int low);
        int got, fin;
        got = 0; fin = 0; low = 0;
        @(negedge clk);
        cmd_valid = 1'b1; command = 8'd8; address = '0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            if (ready) got = 1;
            else @(negedge clk);
        end
        check("clear_accept", got, 32'd1);
        @(posedge clk);
        for (int i = 0; i < 20000 && fin == 0; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (ready) fin = 1;
            else low++;
        end
        check("clear_done", fin, 32'd1);
    endtask

    task automatic expect_resp(input string n, input int lat, input int h, input int m, input int nops);
        check({n, "_lat"},  r_lat,  lat);
        check({n, "_hit"},  r_hit,  h);
        check({n, "_miss"}, r_miss, m);
        check({n, "_nops"}, r_nops, nops);
    endtask

    task automatic expect_op(input string n, input int k, input logic [2:0] op, input logic [31:0] a);
        if (k == 0) begin
            check({n, "_op0"},   r_op0,   op);
            check({n, "_addr0"}, r_addr0, a);
        end else begin
            check({n, "_op1"},   r_op1,   op);
            check({n, "_addr1"}, r_addr1, a);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; command = '0; address = '0; sharedBus = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",      ready,      0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_hit",        hit,        0);
        check("rst_miss",       miss,       0);
        check("rst_busValid",   busValid,   0);
        check("rst_busOp",      busOp,      0);
        check("rst_busAddr",    busAddr,    0);
        check("rst_snoopBus",   snoopBus,   0);

        // Reset sweep: 16384 posedges, release at a negedge.
        rst_n = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 20000 && !ready; i++) begin
            @(negedge clk);
            if (!ready) low_cnt++;
        end
        check("rst_sweep_len", low_cnt, 16383);

        // 1: read miss then read hit, line becomes E
        run_cmd(8'd0, 32'h0000_1040, 2'd0);
        expect_resp("rd_miss", 3, 0, 1, 1);
        expect_op("rd_miss", 0, 3'd1, 32'h0000_1040);
        run_cmd(8'd0, 32'h0000_1040, 2'd0);
        expect_resp("rd_hit", 2, 1, 0, 0);

        // 2: write hit on E -> M silently; snoop read of M -> WB, HITM, S
        run_cmd(8'd1, 32'h0000_1040, 2'd0);
        expect_resp("wr_hitE", 2, 1, 0, 0);
        run_cmd(8'd4, 32'h0000_1040, 2'd0);
        expect_resp("snrd_M", 3, 1, 0, 1);
        expect_op("snrd_M", 0, 3'd2, 32'h0000_1040);
        check("snrd_M_snoop", r_snoop, 2);
        run_cmd(8'd1, 32'h0000_1040, 2'd0);
        expect_resp("wr_hitS", 3, 1, 0, 1);
        expect_op("wr_hitS", 0, 3'd3, 32'h0000_1040);

        // 3: fill set 1 shared, 9th tag evicts PLRU way 0
        for (int t = 0; t < 8; t++) begin
            run_cmd(8'd0, 32'(t << 20) | 32'h40, 2'd1);
            check("fill1_miss", r_miss, 1);
            check("fill1_nops", r_nops, 1);
        end
        run_cmd(8'd0, 32'h0080_0040, 2'd1);
        expect_resp("evict1", 3, 0, 1, 1);
        expect_op("evict1", 0, 3'd1, 32'h0080_0040);
        run_cmd(8'd0, 32'h0000_0040, 2'd1);
        check("evicted_tag0_miss", r_miss, 1);
        run_cmd(8'd0, 32'h0010_0040, 2'd1);
        check("kept_tag1_hit", r_hit, 1);

        // 4: set 2 filled with M lines, write miss with dirty victim
        for (int t = 0; t < 8; t++) begin
            run_cmd(8'd1, 32'(t << 20) | 32'h80, 2'd0);
            check("fill2_lat", r_lat, 3);
            check("fill2_op", r_op0, 3'd4);
        end
        run_cmd(8'd1, 32'h0080_0080, 2'd0);
        expect_resp("dirty_miss", 4, 0, 1, 2);
        expect_op("dirty_miss", 0, 3'd2, 32'h0000_0080);
        expect_op("dirty_miss", 1, 3'd4, 32'h0080_0080);

        // 5: S line upgraded by INVALIDATE, then snoop RWIM takes it away
        run_cmd(8'd2, 32'h0030_0040, 2'd1);
        expect_resp("ifetch_hitS", 2, 1, 0, 0);
        run_cmd(8'd1, 32'h0030_0040, 2'd1);
        expect_resp("upgrade", 3, 1, 0, 1);
        expect_op("upgrade", 0, 3'd3, 32'h0030_0040);
        run_cmd(8'd6, 32'h0030_0040, 2'd0);
        expect_resp("snrwim_M", 3, 1, 0, 1);
        expect_op("snrwim_M", 0, 3'd2, 32'h0030_0040);
        check("snrwim_M_snoop", r_snoop, 2);
        run_cmd(8'd0, 32'h0030_0040, 2'd0);
        expect_resp("after_rwim", 3, 0, 1, 1);
        expect_op("after_rwim", 0, 3'd1, 32'h0030_0040);

        // snoop invalidate, snoop write, snoop read of absent line
        run_cmd(8'd3, 32'h0010_0040, 2'd0);
        check("sninv_snoop", r_snoop, 1);
        check("sninv_nops", r_nops, 0);
        check("sninv_miss", r_miss, 0);
        run_cmd(8'd0, 32'h0010_0040, 2'd0);
        check("after_inv_miss", r_miss, 1);
        run_cmd(8'd5, 32'h0020_0040, 2'd0);
        check("snwr_snoop", r_snoop, 0);
        check("snwr_nops", r_nops, 0);
        run_cmd(8'd4, 32'h0150_0040, 2'd0);
        check("snrd_absent_snoop", r_snoop, 0);
        check("snrd_absent_miss", r_miss, 0);

        // 6: clear mid-trace, everything misses afterwards
        do_clear(low_cnt);
        check("clear_len", low_cnt, 16384);
        run_cmd(8'd0, 32'h0000_1040, 2'd0);
        expect_resp("clr_rd", 3, 0, 1, 1);
        run_cmd(8'd0, 32'h0020_0040, 2'd0);
        check("clr_rd2_miss", r_miss, 1);
        run_cmd(8'd4, 32'h0000_1040, 2'd0);
        expect_resp("snrd_E", 2, 1, 0, 0);
        check("snrd_E_snoop", r_snoop, 1);
        run_cmd(8'd1, 32'h0000_1040, 2'd0);
        expect_op("wr_after_snrdE", 0, 3'd3, 32'h0000_1040);
        run_cmd(8'd9, 32'h0000_1040, 2'd0);
        expect_resp("print", 2, 0, 0, 0);
        check("print_snoop", r_snoop, 0);
        run_cmd(8'd7, 32'h0000_1040, 2'd0);
        expect_resp("cmd7", 2, 0, 0, 0);
        run_cmd(8'd200, 32'h0000_1040, 2'd0);
        expect_resp("cmd200", 2, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_cache.md
Name: l2_cache

Overview:
- Tag/state model of a shared-bus L2 cache: 8-way set-associative, MESI coherence, tree pseudo-LRU replacement.
- Sits between the L1 I/D caches and the shared system bus.
- Accepts one trace command (L1 request, snooped bus op, clear, print) at a time and issues bus operations.
- Drives a snoop result; reports hit/miss.
- No data array; only tags, MESI state and PLRU bits are stored.

Parameters:
- ways, 8, associativity; must be 8 (7-bit PLRU tree).
- indexBits, 14, set index width; 2^indexBits sets.
- lineSize, 512, line size in bits; offsetBits = log2(lineSize/8) = 6.
- tagBits, 10, stored tag width.
- commandSize, 8, command width.
- instructionSize, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command/address valid.
- command  in  commandSize  trace command code.
- address  in  instructionSize  byte address.
- ready  out  1  idle; command accepted when cmd_valid&&ready.
- resp_valid  out  1  one-cycle pulse, command completed.
- hit  out  1  valid with resp_valid; tag matched a non-I way.
- miss  out  1  valid with resp_valid; L1 command (0/1/2) missed.
- busValid  out  1  one-cycle pulse, bus op issued.
- busOp  out  3  0 NONE, 1 READ, 2 WRITE (writeback), 3 INVALIDATE, 4 RWIM.
- busAddr  out  instructionSize  line-aligned bus address (offset bits zero).
- sharedBus  in  2  other caches' snoop result, sampled in the busValid cycle: 0 NOHIT, 1 HIT, 2 HITM.
- snoopBus  out  2  our snoop result for commands 3-6, driven in the resp_valid cycle; NOHIT otherwise.

Behaviour:
- Address split: offset [5:0], index [19:6], tag [29:20]; bits [31:30] ignored.
- MESI per way: I=0, S=1, E=2, M=3.
- FSM states: CLEAR, IDLE, LOOKUP, WB, BUS, RESP.
- Reset, and command 8, enter CLEAR. CLEAR sweeps one set per cycle from set 0 to 2^indexBits-1: every way to I, PLRU to 0. It then goes to IDLE.
- Reset values: ready=0, resp_valid=0, hit=0, miss=0, busValid=0, busOp=0, busAddr=0, snoopBus=0. Reset mid-operation aborts the command and restarts CLEAR.
- ready=1 only in IDLE. Accept goes to LOOKUP (tag compare on all ways), then WB/BUS as needed, then RESP (resp_valid=1), then IDLE.
- Hit latency: resp_valid 2 cycles after accept. Clean miss: 3 cycles. Dirty-victim miss: 4 cycles.
- Victim selection: lowest-numbered I way, else PLRU victim.
- PLRU updates on commands 0/1/2 only; it points away from the accessed way.
- Read (0, 2):
  - Hit: no state change.
  - Miss: if victim is M, WB state issues WRITE with the victim address. BUS issues READ; new state is E if sharedBus==NOHIT, else S.
- Write (1):
  - Hit M or E: goes to M, no bus op.
  - Hit S: BUS issues INVALIDATE, then M.
  - Miss: victim writeback if M, BUS issues RWIM, then M.
- Snoop invalidate (3): S goes to I; snoopBus=HIT if present, else NOHIT.
- Snoop read (4):
  - M: WB issues WRITE, goes to S, HITM.
  - E: goes to S, HIT.
  - S: stays S, HIT.
  - I: NOHIT.
- Snoop write (5): no change, NOHIT.
- Snoop RWIM (6):
  - M: WB issues WRITE, goes to I, HITM.
  - E or S: goes to I, HIT.
- Snoops never set miss.
- Command 9: no state change; resp_valid with hit=miss=0. Any printing is done by the bench.
- Commands 7 and 10-255: treated like 9.
- cmd_valid while ready=0 is ignored; the source holds it until accepted.

Decomposition:
- Package l2_cache_pkg holds: MESI enum, busOp codes, snoop result codes, command codes, FSM state enum.
- One sub-module, l2_plru8: purely combinational. Victim from 7 tree bits; updated tree bits from accessed way.

Test Plan:
1. Reset, wait for ready; read 0x00001040 (cmd 0). Expect miss=1, busOp READ, busAddr 0x00001040. With sharedBus=NOHIT, a repeat read gives hit=1 and the line is E.
2. Write (cmd 1) to 0x00001040 after scenario 1. Expect hit=1, no busValid, state M. Snoop read (cmd 4) of the same address: expect WRITE 0x00001040, snoopBus=HITM, state S.
3. Fill set 1 with 8 read misses, tags 0..7 (address = tag<<20 | 0x40), sharedBus=HIT so all are S. A 9th tag 8 evicts PLRU way 0: no WB, busOp READ 0x00800040.
4. Write miss into a set whose PLRU victim is M. Expect WRITE of the victim address, then RWIM of the new address; resp_valid 4 cycles after accept.
5. Read to S line, then cmd 1. Expect INVALIDATE. Snoop RWIM (cmd 6) then gives HITM with writeback and state I; a following read misses.
6. Cmd 8 mid-trace. Expect ready=0 for 2^14 cycles, then all earlier lines miss. Cmd 9 and cmd 7 give resp_valid with hit=miss=0 and no bus op.
